// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART state encoding, frame constants and baud helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic int baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Brief    : Byte handshake between a byte source and the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_ready;
    logic       uart_tx_busy;
    logic       uart_tx_done;

    modport master (
        output uart_tx_en,
        output uart_tx_data,
        input  uart_tx_ready,
        input  uart_tx_busy,
        input  uart_tx_done
    );

    modport slave (
        input  uart_tx_en,
        input  uart_tx_data,
        output uart_tx_ready,
        output uart_tx_busy,
        output uart_tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Bit-period counter 0..BAUD_CNT_MAX-1 with a tick on the last count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int BAUD_CNT_MAX = 434
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_run,
    input  wire logic        i_restart,
    output logic      [15:0] o_bd_cnt,
    output logic             o_tick
);
    localparam logic [15:0] C_LAST = 16'(BAUD_CNT_MAX - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_restart || !i_run) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_bd_cnt = r_cnt;
    assign o_tick   = i_run && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter, LSB first; define UART_TX_PARITY_EN for 8E1/8O1.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int PARITY_ODD = 0
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_tx_if.slave  tx_if,
    output logic      uart_txd
);
    localparam int          BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam logic [15:0] C_BD_LAST    = 16'(BAUD_CNT_MAX - 1);
    localparam logic [2:0]  C_LAST_BIT   = 3'(UART_DATA_BITS - 1);

    uart_state_e r_state;
    uart_state_e w_state_next;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_txd;
    logic        w_txd_next;
    logic        w_accept;
    logic        w_run;
    logic        w_tick;
    logic [15:0] w_bd_cnt;

`ifdef UART_TX_PARITY_EN
    logic r_parity;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign w_accept = tx_if.uart_tx_en && (r_state == ST_IDLE);
    assign w_run    = (r_state != ST_IDLE);

    uart_baud_gen #(
        .BAUD_CNT_MAX (BAUD_CNT_MAX)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_run),
        .i_restart (w_accept),
        .o_bd_cnt  (w_bd_cnt),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_txd     <= 1'b1;
            r_shift   <= 8'd0;
            r_bit_cnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_txd   <= w_txd_next;
            if (w_accept) begin
                r_shift   <= tx_if.uart_tx_data;
                r_bit_cnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
                r_parity  <= (^tx_if.uart_tx_data) ^ (PARITY_ODD != 0);
`endif
            end else if ((r_state == ST_DATA) && w_tick) begin
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // Next line level is chosen here and registered, so the pin never sees FSM decode glitches.
    always_comb begin
        w_state_next = r_state;
        w_txd_next   = r_txd;
        case (r_state)
            ST_IDLE: begin
                w_txd_next = 1'b1;
                if (w_accept) begin
                    w_state_next = ST_START;
                    w_txd_next   = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_txd_next   = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
                        w_txd_next   = r_parity;
`else
                        w_state_next = ST_STOP;
                        w_txd_next   = 1'b1;
`endif
                    end else begin
                        w_txd_next = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (w_tick) begin
                    w_state_next = ST_STOP;
                    w_txd_next   = 1'b1;
                end
`else
                w_state_next = ST_IDLE;
                w_txd_next   = 1'b1;
`endif
            end
            ST_STOP: begin
                w_txd_next = 1'b1;
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
    end

    assign tx_if.uart_tx_ready = (r_state == ST_IDLE);
    assign tx_if.uart_tx_busy  = (r_state != ST_IDLE);
    assign tx_if.uart_tx_done  = (r_state == ST_STOP) && (w_bd_cnt == C_BD_LAST);
    assign uart_txd            = r_txd;

endmodule
`default_nettype wire
